// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates NUM_CH requesters onto one byte-wide RAM/IO port
// and serialises 1/2/4-byte little-endian reads and writes, with replay of the
// last read address after an rdy_in pause (the RAM answers one cycle late).
module mem_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int RR_EN  = 0,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy_in,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [2*NUM_CH-1:0]      len_i,
  input  logic [ADDR_W*NUM_CH-1:0] addr_i,
  input  logic [32*NUM_CH-1:0]     wdata_i,
  output logic [31:0]              rdata_o,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH-1:0]        stall_o,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wr
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     rrptr_q, rrptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              prev_low_q;

  logic [NUM_CH-1:0] elig_s;
  logic              found_s;
  logic [GW-1:0]     pick_s;
  logic [GW:0]       cand_s;
  logic              sel_we_s;
  logic [1:0]        sel_len_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic              replay_s;
  logic              capture_s;

  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign stall_o = req_i & ~done_q;

  // Pick the winning channel: lowest eligible index, or first eligible after rrptr.
  always_comb begin
    elig_s  = req_i & ~done_q;
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (RR_EN != 0) begin
        cand_s  = {1'b0, rrptr_q} + (GW+1)'(i + 1);
        cand_s  = (cand_s >= (GW+1)'(NUM_CH)) ? cand_s - (GW+1)'(NUM_CH) : cand_s;
        pick_s  = (!found_s && elig_s[cand_s[GW-1:0]]) ? cand_s[GW-1:0] : pick_s;
        found_s = found_s | elig_s[cand_s[GW-1:0]];
      end else begin
        pick_s  = (!found_s && elig_s[i]) ? GW'(i) : pick_s;
        found_s = found_s | elig_s[i];
      end
    end
  end

  // Route the winning channel's request fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_len_s   = 2'd0;
    sel_addr_s  = '0;
    sel_wdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_we_s    = (pick_s == GW'(i)) ? we_i[i]                   : sel_we_s;
      sel_len_s   = (pick_s == GW'(i)) ? len_i[2*i +: 2]           : sel_len_s;
      sel_addr_s  = (pick_s == GW'(i)) ? addr_i[ADDR_W*i +: ADDR_W] : sel_addr_s;
      sel_wdata_s = (pick_s == GW'(i)) ? wdata_i[32*i +: 32]       : sel_wdata_s;
    end
  end

  // Next-state logic and RAM port drive for the IDLE/READ/WRITE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    rrptr_d  = rrptr_q;
    base_d   = base_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    done_d   = rdy_in ? '0 : done_q;
    mem_addr = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    // First active cycle after a pause re-issues the previous read address,
    // because the RAM byte for it was lost while frozen.
    replay_s  = prev_low_q & rdy_in & (state_q == S_READ) & (cnt_q != 3'd0);
    capture_s = rdy_in & ~replay_s & (state_q == S_READ) & (cnt_q != 3'd0);
    case (state_q)
      S_IDLE: begin
        if (rdy_in && found_s) begin
          gnt_d   = pick_s;
          rrptr_d = pick_s;
          base_d  = sel_addr_s;
          len_d   = (sel_len_s == 2'd2) ? 2'd3 : sel_len_s;
          wdata_d = sel_wdata_s;
          data_d  = 32'h0000_0000;
          cnt_d   = 3'd0;
          state_d = sel_we_s ? S_WRITE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (replay_s) begin
          mem_addr = base_q + ADDR_W'(cnt_q) - ADDR_W'(1);
        end else if (cnt_q <= {1'b0, len_q}) begin
          mem_addr = base_q + ADDR_W'(cnt_q);
        end else begin
          mem_addr = '0;
        end
        for (int b = 0; b < 4; b++) begin
          data_d[8*b +: 8] = (capture_s && (cnt_q == 3'(b + 1))) ? mem_din : data_q[8*b +: 8];
        end
        if (rdy_in && !replay_s) begin
          if (cnt_q == ({1'b0, len_q} + 3'd1)) begin
            rdata_d        = data_d;
            done_d         = '0;
            done_d[gnt_q]  = 1'b1;
            cnt_d          = 3'd0;
            state_d        = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WRITE: begin
        mem_wr   = rdy_in;
        mem_addr = base_q + ADDR_W'(cnt_q);
        mem_dout = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
        if (rdy_in) begin
          if (cnt_q == {1'b0, len_q}) begin
            done_d        = '0;
            done_d[gnt_q] = 1'b1;
            cnt_d         = 3'd0;
            state_d       = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; rdy_in history is tracked even while frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      gnt_q      <= '0;
      rrptr_q    <= GW'(NUM_CH - 1);
      base_q     <= '0;
      len_q      <= 2'd0;
      wdata_q    <= 32'h0000_0000;
      data_q     <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      done_q     <= '0;
      prev_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rrptr_q    <= rrptr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      prev_low_q <= ~rdy_in;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a fixed-priority and a round-robin
// instance (NUM_CH=3), each with its own synchronous byte-RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [2:0]  req_f, req_r, we;
  logic [5:0]  len;
  logic [95:0] addr, wdata;

  logic [31:0] rdata_f, rdata_r, addr_f, addr_r;
  logic [2:0]  done_f, done_r, stall_f, stall_r;
  logic [7:0]  din_f, din_r, dout_f, dout_r;
  logic        wr_f, wr_r;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(3), .RR_EN(0), .ADDR_W(32)) u_fix (
    .clk(clk), .rst(rst), .rdy_in(rdy), .req_i(req_f), .we_i(we), .len_i(len),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_f), .done_o(done_f), .stall_o(stall_f),
    .mem_din(din_f), .mem_dout(dout_f), .mem_addr(addr_f), .mem_wr(wr_f));

  mem_port_arbiter #(.NUM_CH(3), .RR_EN(1), .ADDR_W(32)) u_rr (
    .clk(clk), .rst(rst), .rdy_in(rdy), .req_i(req_r), .we_i(we), .len_i(len),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_r), .done_o(done_r), .stall_o(stall_r),
    .mem_din(din_r), .mem_dout(dout_r), .mem_addr(addr_r), .mem_wr(wr_r));

  // RAM contents before any write: a few fixed bytes, otherwise a pattern.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'hFFFF_FFFE: return 8'hA1;
      32'hFFFF_FFFF: return 8'hB2;
      32'h0000_0000: return 8'hC3;
      32'h0000_0001: return 8'hD4;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] ram_f [0:4095];
  bit         wv_f  [0:4095];

  function automatic logic [7:0] rd_f(input logic [31:0] a);
    return wv_f[a[11:0]] ? ram_f[a[11:0]] : init_byte(a);
  endfunction

  // Synchronous RAM for the fixed-priority instance.
  always @(posedge clk) begin
    if (wr_f) begin
      ram_f[addr_f[11:0]] <= dout_f;
      wv_f[addr_f[11:0]]  <= 1'b1;
    end
    din_f <= rd_f(addr_f);
  end

  // Read-only RAM for the round-robin instance.
  always @(posedge clk) begin
    din_r <= init_byte(addr_r);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int enc(input logic [2:0] d);
    case (d)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 7;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]  ch;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  lat;       // negedges after the request until done_o
    logic [3:0]  chkc;      // negedge at which the last byte is on the port
    logic [31:0] exp_addr;  // mem_addr at chkc
    logic [31:0] exp_data;  // rdata_o for reads, mem_dout at chkc for writes
  } vec_t;

  vec_t vecs [9];

  initial begin
    int c, got, lat, nd, bad;
    logic [31:0] s_addr, s_dout;
    logic s_wr, s_st1;
    int ord_f [3];
    int ord_r [10];
    int exp_rr [10];

    vecs[0] = '{2'd0, 1'b0, 2'd3, 32'h0000_0100, 32'h0, 4'd6, 4'd4, 32'h0000_0103, 32'h4433_2211};
    vecs[1] = '{2'd0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, 4'd6, 4'd4, 32'h0000_0001, 32'hD4C3_B2A1};
    vecs[2] = '{2'd1, 1'b1, 2'd0, 32'h0003_0000, 32'h41, 4'd2, 4'd1, 32'h0003_0000, 32'h41};
    vecs[3] = '{2'd2, 1'b1, 2'd1, 32'h0000_0200, 32'hBEEF, 4'd3, 4'd2, 32'h0000_0201, 32'hBE};
    vecs[4] = '{2'd0, 1'b0, 2'd1, 32'h0000_0200, 32'h0, 4'd4, 4'd2, 32'h0000_0201, 32'h0000_BEEF};
    vecs[5] = '{2'd1, 1'b0, 2'd0, 32'h0003_0000, 32'h0, 4'd3, 4'd1, 32'h0003_0000, 32'h0000_0041};
    vecs[6] = '{2'd2, 1'b1, 2'd3, 32'h0000_0400, 32'hDEAD_BEEF, 4'd5, 4'd4, 32'h0000_0403, 32'hDE};
    vecs[7] = '{2'd1, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 4'd6, 4'd4, 32'h0000_0403, 32'hDEAD_BEEF};
    vecs[8] = '{2'd2, 1'b0, 2'd0, 32'h0000_07F3, 32'h0, 4'd3, 4'd1, 32'h0000_07F3, 32'h0000_00A9};
    exp_rr = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};

    rst = 1'b0; rdy = 1'b1; req_f = 3'b000; req_r = 3'b000;
    we = 3'b000; len = 6'd0; addr = 96'd0; wdata = 96'd0;

    // Reset values
    @(negedge clk);
    chk("rst_mem_addr", addr_f, 32'h0);
    chk("rst_mem_wr", 32'(wr_f), 32'h0);
    chk("rst_mem_dout", 32'(dout_f), 32'h0);
    chk("rst_rdata", rdata_f, 32'h0);
    chk("rst_done", 32'(done_f), 32'h0);
    chk("rst_stall", 32'(stall_f), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single-transaction vectors on the fixed-priority instance
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      c = int'(vecs[k].ch);
      we[c] = vecs[k].we;
      len[2*c +: 2] = vecs[k].len;
      addr[32*c +: 32] = vecs[k].addr;
      wdata[32*c +: 32] = vecs[k].wdata;
      req_f[c] = 1'b1;
      got = 0; lat = 0; s_addr = 32'h0; s_dout = 32'h0; s_wr = 1'b0; s_st1 = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (n == 1) s_st1 = stall_f[c];
        if (n == int'(vecs[k].chkc)) begin
          s_addr = addr_f; s_dout = 32'(dout_f); s_wr = wr_f;
        end
        if (done_f != 3'b000) begin
          got = 1; lat = n;
          break;
        end
      end
      chk($sformatf("v%0d_done_seen", k), 32'(got), 32'd1);
      chk($sformatf("v%0d_done_mask", k), 32'(done_f), 32'(1 << c));
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
      chk($sformatf("v%0d_last_addr", k), s_addr, vecs[k].exp_addr);
      chk($sformatf("v%0d_stall_busy", k), 32'(s_st1), 32'd1);
      chk($sformatf("v%0d_stall_done", k), 32'(stall_f[c]), 32'd0);
      if (vecs[k].we) begin
        chk($sformatf("v%0d_dout", k), s_dout, vecs[k].exp_data);
        chk($sformatf("v%0d_wr", k), 32'(s_wr), 32'd1);
      end else begin
        chk($sformatf("v%0d_rdata", k), rdata_f, vecs[k].exp_data);
      end
      req_f[c] = 1'b0;
      @(negedge clk);
    end

    // Fixed priority: each channel requests once, drops after its done_o
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; len[2*i +: 2] = 2'd0; addr[32*i +: 32] = 32'h10 + 32'(i);
    end
    @(negedge clk);
    req_f = 3'b111; nd = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_f != 3'b000) begin
        ord_f[nd] = enc(done_f);
        req_f = req_f & ~done_f;
        nd++;
        if (nd == 3) break;
      end
    end
    req_f = 3'b000;
    chk("fix_done_count", 32'(nd), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("fix_order%0d", i), 32'(ord_f[i]), 32'(i));

    // Round-robin: all three continuously, then ch0 and ch2 only
    @(negedge clk);
    req_r = 3'b111; nd = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (done_r != 3'b000) begin
        ord_r[nd] = enc(done_r);
        nd++;
        if (nd == 6) req_r = 3'b101;
        if (nd == 10) break;
      end
    end
    req_r = 3'b000;
    chk("rr_done_count", 32'(nd), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("rr_order%0d", i), 32'(ord_r[i]), 32'(exp_rr[i]));
    @(negedge clk);

    // Pause of three cycles mid-read, then one replay cycle
    we[0] = 1'b0; len[1:0] = 2'd3; addr[31:0] = 32'h0000_0100;
    req_f[0] = 1'b1; got = 0; lat = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (done_f != 3'b000) begin
        got = 1; lat = n;
        break;
      end
      if (n == 3) begin
        chk("pause_addr_pre", addr_f, 32'h0000_0102);
        rdy = 1'b0;
      end
      if (n == 6) begin
        rdy = 1'b1;
        #1;
        chk("replay_addr", addr_f, 32'h0000_0101);
      end
    end
    rdy = 1'b1;
    chk("pause_done_seen", 32'(got), 32'd1);
    chk("pause_latency", 32'(lat), 32'd10);
    chk("pause_done_mask", 32'(done_f), 32'h1);
    chk("pause_rdata", rdata_f, 32'h4433_2211);
    req_f[0] = 1'b0;
    @(negedge clk);

    // Reset asserted in the middle of a 4-byte write
    @(negedge clk);
    we[1] = 1'b1; len[3:2] = 2'd3; addr[63:32] = 32'h0000_0500; wdata[63:32] = 32'h1234_5678;
    req_f[1] = 1'b1;
    @(negedge clk);
    chk("wr_b0_wr", 32'(wr_f), 32'd1);
    chk("wr_b0_addr", addr_f, 32'h0000_0500);
    chk("wr_b0_dout", 32'(dout_f), 32'h78);
    @(negedge clk);
    chk("wr_b1_addr", addr_f, 32'h0000_0501);
    chk("wr_b1_dout", 32'(dout_f), 32'h56);
    rst = 1'b0; req_f = 3'b000;
    #1;
    chk("rst_wr_same_cycle", 32'(wr_f), 32'd0);
    chk("rst_addr_same_cycle", addr_f, 32'h0);
    chk("rst_done_same_cycle", 32'(done_f), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_rdata_fix", rdata_f, 32'h0);
    chk("rst_rdata_rr", rdata_r, 32'h0);
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_f != 3'b000 || wr_f) bad++;
    end
    chk("no_done_after_rst", 32'(bad), 32'd0);
    chk("abandoned_byte2", 32'(wv_f[12'h502]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
